// File: rtl/ni_target_req_decoder_if.sv
// Bundle between the NoC target request decoder and its neighbours: request flit
// input, AXI AW/W/AR master channels and the response-tracking push port.
interface ni_target_req_decoder_if #(
    parameter int FLIT_WIDTH = 80,
    parameter int AXIIDWD    = 4,
    parameter int AXIDATAWD  = 64
);
    logic [FLIT_WIDTH-1:0]    flit;
    logic                     valid;
    logic                     stall;

    logic [AXIIDWD-1:0]       AWID;
    logic [31:0]              AWADDR;
    logic [7:0]               AWLEN;
    logic [2:0]               AWSIZE;
    logic [1:0]               AWBURST;
    logic                     AWVALID;
    logic                     AWREADY;

    logic [AXIDATAWD-1:0]     WDATA;
    logic [AXIDATAWD/8-1:0]   WSTRB;
    logic                     WLAST;
    logic                     WVALID;
    logic                     WREADY;

    logic [AXIIDWD-1:0]       ARID;
    logic [31:0]              ARADDR;
    logic [7:0]               ARLEN;
    logic [2:0]               ARSIZE;
    logic [1:0]               ARBURST;
    logic                     ARVALID;
    logic                     ARREADY;

    logic                     txn_push;
    logic [3:0]               txn_source;
    logic [AXIIDWD-1:0]       txn_id;
    logic                     txn_write;
    logic                     txn_full;
    logic                     protocol_error;

    modport master (
        input  flit, valid, AWREADY, WREADY, ARREADY, txn_full,
        output stall,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output txn_push, txn_source, txn_id, txn_write, protocol_error
    );

    modport slave (
        output flit, valid, AWREADY, WREADY, ARREADY, txn_full,
        input  stall,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  txn_push, txn_source, txn_id, txn_write, protocol_error
    );
endinterface

// File: rtl/ni_target_req_decoder.sv
// Decodes NoC request packets into AXI AR / AW+W transactions, records each accepted
// header for the response path and flags malformed packets with a sticky error.
module ni_target_req_decoder #(
    parameter int FLIT_WIDTH = 80,
    parameter int AXIIDWD    = 4,
    parameter int AXIDATAWD  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    ni_target_req_decoder_if.master bus
);
    localparam int STRBWD = AXIDATAWD / 8;

    typedef enum logic [2:0] {IDLE, AR_ISSUE, AW_ISSUE, W_DATA, DROP} state_t;

    state_t               state, next_state;

    logic [AXIIDWD-1:0]   hdr_id;
    logic [31:0]          hdr_addr;
    logic [7:0]           hdr_len;
    logic [2:0]           hdr_size;
    logic [1:0]           hdr_burst;
    logic [7:0]           beat_cnt;
    logic                 beats_done;
    logic                 err_q;

    logic                 f_head, f_tail, f_write;
    logic                 stall_c, accept_hdr, set_err, w_valid, w_hs, aw_hs;

    assign f_head  = bus.flit[FLIT_WIDTH-1];
    assign f_tail  = bus.flit[FLIT_WIDTH-2];
    assign f_write = bus.flit[73];
    assign aw_hs   = (state == AW_ISSUE) && bus.AWREADY;

    always_comb begin
        next_state = state;
        stall_c    = 1'b0;
        accept_hdr = 1'b0;
        set_err    = 1'b0;
        w_valid    = 1'b0;
        w_hs       = 1'b0;
        case (state)
            IDLE: begin
                stall_c = bus.txn_full;
                if (bus.valid && !bus.txn_full) begin
                    if (!f_head) begin
                        set_err = 1'b1;
                        if (!f_tail) next_state = DROP;
                    end else if (f_tail && !f_write) begin
                        accept_hdr = 1'b1;
                        next_state = AR_ISSUE;
                    end else if (!f_tail && f_write) begin
                        accept_hdr = 1'b1;
                        next_state = AW_ISSUE;
                    end else if (!f_tail) begin
                        set_err    = 1'b1;
                        next_state = DROP;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            AR_ISSUE: begin
                stall_c = 1'b1;
                if (bus.ARREADY) next_state = IDLE;
            end
            AW_ISSUE: begin
                stall_c = 1'b1;
                if (bus.AWREADY) next_state = W_DATA;
            end
            W_DATA: begin
                // After LEN+1 beats every further flit is surplus: swallow it without a W beat
                if (beats_done) begin
                    if (bus.valid) begin
                        set_err    = 1'b1;
                        next_state = f_tail ? IDLE : DROP;
                    end
                end else begin
                    w_valid = bus.valid;
                    stall_c = !bus.WREADY;
                    if (bus.valid && bus.WREADY) begin
                        w_hs = 1'b1;
                        if (f_tail) begin
                            next_state = IDLE;
                            if (beat_cnt != hdr_len) set_err = 1'b1;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.valid && f_tail) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_id    <= '0;
            hdr_addr  <= '0;
            hdr_len   <= '0;
            hdr_size  <= '0;
            hdr_burst <= '0;
        end else if (accept_hdr) begin
            hdr_id    <= bus.flit[69 +: AXIIDWD];
            hdr_len   <= bus.flit[68:61];
            hdr_size  <= bus.flit[60:58];
            hdr_burst <= bus.flit[57:56];
            hdr_addr  <= bus.flit[55:24];
        end
    end

    // beats_done marks that LEN+1 beats went out, so an 8-bit counter never has to exceed 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            beats_done <= 1'b0;
        end else if (aw_hs) begin
            beat_cnt   <= '0;
            beats_done <= 1'b0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (!f_tail && (beat_cnt == hdr_len)) beats_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (set_err) err_q <= 1'b1;
    end

    assign bus.stall          = stall_c & ~rst;
    assign bus.txn_push       = accept_hdr & ~rst;
    assign bus.txn_source     = bus.txn_push ? bus.flit[77:74] : 4'd0;
    assign bus.txn_id         = bus.txn_push ? bus.flit[69 +: AXIIDWD] : '0;
    assign bus.txn_write      = bus.txn_push & f_write;
    assign bus.protocol_error = err_q;

    assign bus.AWID    = hdr_id;
    assign bus.AWADDR  = hdr_addr;
    assign bus.AWLEN   = hdr_len;
    assign bus.AWSIZE  = hdr_size;
    assign bus.AWBURST = hdr_burst;
    assign bus.AWVALID = (state == AW_ISSUE);

    assign bus.ARID    = hdr_id;
    assign bus.ARADDR  = hdr_addr;
    assign bus.ARLEN   = hdr_len;
    assign bus.ARSIZE  = hdr_size;
    assign bus.ARBURST = hdr_burst;
    assign bus.ARVALID = (state == AR_ISSUE);

    assign bus.WVALID  = w_valid;
    assign bus.WDATA   = (state == W_DATA) ? bus.flit[AXIDATAWD-1:0] : '0;
    assign bus.WSTRB   = (state == W_DATA) ? bus.flit[AXIDATAWD +: STRBWD] : '0;
    assign bus.WLAST   = (state == W_DATA) & f_tail;
endmodule
